// File: rtl/opener_pkg.sv
// ---------------------------------------------------------------------------
// opener_pkg
// Shared definitions for the timed opener controller:
//   state_t    - FSM state type, with encodings visible on the State port
//   cnt_width  - width of the travel/idle counters for a given pair of limits
// ---------------------------------------------------------------------------
package opener_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Enough bits to hold max(a, b) without wrapping; never narrower than 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Saturating cycle counter with terminal-count flag.
//   clk    : clock
//   rst    : async active-high reset, count -> 0
//   clear  : synchronous clear, highest priority after reset
//   enable : count this cycle
//   last   : terminal value; tc is raised while enabled and count == last
//   tc     : terminal-count flag (combinational)
// tc means "this enabled cycle is the (last+1)-th counted cycle", so the
// owner can act on the edge that ends it.
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = enable && (count == last);

endmodule

// File: rtl/timed_opener.sv
// ---------------------------------------------------------------------------
// timed_opener
// Door/gate opener controller with travel timeout, idle auto-close and a
// limit on obstruction reversals.
//   clk   : clock
//   r     : async active-high reset (holds FSM in Resolve)
//   b     : push button
//   c     : fully-closed limit switch
//   o     : fully-open limit switch
//   s     : obstruction sensor
//   d     : motor down (Closing)
//   u     : motor up (Opening)
//   fault : latched fault indication
//   State : current FSM state encoding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CLOSED   | at closed limit, waiting for button
// OPENING  | motor up until open limit or travel timeout
// OPEN     | at open limit, idle timer running for auto-close
// CLOSING  | motor down; obstruction/button reverses, closed limit stops
// RESOLVE  | after reset, decide position from limit switches
// FAULT    | absorbing; left only through reset
// ---------------------------------------------------------------------------
module timed_opener
    import opener_pkg::*;
#(
    parameter int AUTO_CLOSE_CYCLES = 100,
    parameter int TRAVEL_TIMEOUT    = 200,
    parameter int MAX_REVERSALS     = 3
) (
    input  logic       clk,
    input  logic       r,
    input  logic       b,
    input  logic       c,
    input  logic       o,
    input  logic       s,
    output logic       d,
    output logic       u,
    output logic       fault,
    output logic [2:0] State
);

    localparam int CW = cnt_width(AUTO_CLOSE_CYCLES, TRAVEL_TIMEOUT);
    localparam int RW = (MAX_REVERSALS < 2) ? 1 : $clog2(MAX_REVERSALS + 1);

    localparam bit            AC_EN    = (AUTO_CLOSE_CYCLES > 0);
    localparam logic [CW-1:0] AC_LAST  = CW'(AC_EN ? AUTO_CLOSE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TR_LAST  = CW'(TRAVEL_TIMEOUT - 1);
    // A reversal taken while the count sits here would reach the limit.
    localparam logic [RW-1:0] REV_LAST = RW'(MAX_REVERSALS - 1);

    state_t          state;
    state_t          state_next;
    logic [RW-1:0]   rev_cnt;
    logic            rev_hit;
    logic            travel_en;
    logic            travel_clr;
    logic            travel_tc;
    logic            idle_en;
    logic            idle_clr;
    logic            idle_tc;
    logic            idle_done;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------
    // Any state change clears the travel timer, so every entry to Opening
    // or Closing (including a reversal) starts from zero.
    assign travel_en  = (state == ST_OPENING) || (state == ST_CLOSING);
    assign travel_clr = (state_next != state);

    cycle_timer #(.WIDTH(CW)) u_travel_timer (
        .clk    (clk),
        .rst    (r),
        .clear  (travel_clr),
        .enable (travel_en),
        .last   (TR_LAST),
        .tc     (travel_tc)
    );

    // Idle timer only runs in Open; any activity, or not being in Open,
    // holds it at zero so entering Open always starts a fresh count.
    assign idle_en  = (state == ST_OPEN) && !b && !s;
    assign idle_clr = (state != ST_OPEN) || b || s;

    cycle_timer #(.WIDTH(CW)) u_idle_timer (
        .clk    (clk),
        .rst    (r),
        .clear  (idle_clr),
        .enable (idle_en),
        .last   (AC_LAST),
        .tc     (idle_tc)
    );

    assign idle_done = AC_EN && idle_tc;

    // ------------------------------------------------------------------
    // Reversal counter
    // ------------------------------------------------------------------
    assign rev_hit = (rev_cnt == REV_LAST);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            rev_cnt <= '0;
        end else if ((state == ST_CLOSING) && (state_next == ST_CLOSED)) begin
            rev_cnt <= '0;
        end else if ((state == ST_CLOSING) && (state_next == ST_OPENING)
                     && (rev_cnt != '1)) begin
            rev_cnt <= rev_cnt + RW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= ST_RESOLVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESOLVE: begin
                if (c && o) begin
                    state_next = ST_FAULT;
                end else if (c) begin
                    state_next = ST_CLOSED;
                end else if (o) begin
                    state_next = ST_OPEN;
                end else begin
                    state_next = ST_OPENING;
                end
            end
            ST_CLOSED: begin
                if (b) begin
                    state_next = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (o) begin
                    state_next = ST_OPEN;
                end else if (travel_tc) begin
                    state_next = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (b && !s) begin
                    state_next = ST_CLOSING;
                end else if (idle_done) begin
                    state_next = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                // Reversal wins over the closed limit: an obstruction seen
                // on the same edge as c must not let the door latch shut.
                if (s || b) begin
                    state_next = rev_hit ? ST_FAULT : ST_OPENING;
                end else if (c) begin
                    state_next = ST_CLOSED;
                end else if (travel_tc) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase

        // Both limit switches at once is physically impossible; trust nothing.
        if ((state != ST_RESOLVE) && c && o) begin
            state_next = ST_FAULT;
        end
    end

    // Moore outputs straight from the state register, so an async reset
    // into Resolve drops the motor without waiting for an edge.
    always_comb begin
        u     = 1'b0;
        d     = 1'b0;
        fault = 1'b0;
        case (state)
            ST_OPENING: u     = 1'b1;
            ST_CLOSING: d     = 1'b1;
            ST_FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_timed_opener.sv
module tb_timed_opener;

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_CLOSING = 3'd3;
    localparam logic [2:0] S_RESOLVE = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       o = 1'b0;
    logic       s = 1'b0;
    logic       d;
    logic       u;
    logic       fault;
    logic [2:0] State;

    int checks = 0;
    int errors = 0;

    timed_opener #(
        .AUTO_CLOSE_CYCLES (4),
        .TRAVEL_TIMEOUT    (8),
        .MAX_REVERSALS     (2)
    ) dut (
        .clk   (clk),
        .r     (r),
        .b     (b),
        .c     (c),
        .o     (o),
        .s     (s),
        .d     (d),
        .u     (u),
        .fault (fault),
        .State (State)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, b, c, o, s;
        logic [2:0] st;
        logic       eu, ed, ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rr, bb, cc, oo, ss, input logic [2:0] st);
        vec_t v;
        v.r  = rr; v.b = bb; v.c = cc; v.o = oo; v.s = ss;
        v.st = st;
        v.eu = (st == S_OPENING);
        v.ed = (st == S_CLOSING);
        v.ef = (st == S_FAULT);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] est,
                         input logic eu, input logic ed, input logic ef);
        checks++;
        if (State !== est || u !== eu || d !== ed || fault !== ef) begin
            errors++;
            $display("FAIL %s: got State=%0d u=%b d=%b fault=%b, expected State=%0d u=%b d=%b fault=%b",
                     name, State, u, d, fault, est, eu, ed, ef);
        end
    endtask

    task automatic set_in(input logic rr, bb, cc, oo, ss);
        @(negedge clk);
        r = rr; b = bb; c = cc; o = oo; s = ss;
    endtask

    task automatic step(input logic rr, bb, cc, oo, ss);
        set_in(rr, bb, cc, oo, ss);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Table: inputs held for one cycle, expected state after the edge.
        //   r  b  c  o  s   state
        add(1, 0, 0, 0, 0, S_RESOLVE);
        add(0, 0, 0, 0, 0, S_OPENING);   // resolve, neither limit
        add(0, 0, 0, 1, 0, S_OPEN);
        add(1, 0, 0, 1, 0, S_RESOLVE);
        add(0, 0, 1, 0, 0, S_CLOSED);    // resolve at closed limit
        add(0, 1, 1, 0, 0, S_OPENING);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 1
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 2
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 3
        add(0, 0, 0, 1, 0, S_CLOSING);   // idle 4 -> auto-close
        add(0, 0, 0, 0, 0, S_CLOSING);
        add(0, 0, 1, 0, 0, S_CLOSED);
        add(0, 1, 1, 0, 0, S_OPENING);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 0, S_CLOSING);
        add(0, 0, 0, 0, 1, S_OPENING);   // reversal 1
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 0, S_CLOSING);
        add(0, 0, 0, 0, 1, S_FAULT);     // reversal 2 hits limit
        add(1, 0, 0, 0, 0, S_RESOLVE);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 1
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 2
        add(0, 0, 0, 1, 0, S_OPEN);      // idle 3
        add(0, 0, 0, 1, 1, S_OPEN);      // obstruction clears idle count
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 0, 1, 0, S_CLOSING);
        add(0, 0, 1, 0, 1, S_OPENING);   // s beats c, reversal 1
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 0, 1, 1, 0, S_FAULT);     // limit conflict in Open
        add(1, 0, 0, 0, 0, S_RESOLVE);   // reset clears reversal count
        add(0, 0, 1, 1, 0, S_FAULT);     // conflict seen in Resolve
        add(1, 0, 0, 0, 0, S_RESOLVE);
        add(0, 0, 1, 0, 0, S_CLOSED);
        add(0, 1, 1, 0, 0, S_OPENING);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 0, S_CLOSING);
        add(0, 0, 0, 0, 1, S_OPENING);   // reversal 1
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 0, S_CLOSING);
        add(0, 0, 1, 0, 0, S_CLOSED);    // closing clears reversal count
        add(0, 1, 1, 0, 0, S_OPENING);
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 0, S_CLOSING);
        add(0, 0, 0, 0, 1, S_OPENING);   // reversal 1 again, no fault
        add(0, 0, 0, 1, 0, S_OPEN);
        add(0, 1, 0, 1, 1, S_OPEN);      // b with s held open

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].b, vecs[i].c, vecs[i].o, vecs[i].s);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].eu, vecs[i].ed, vecs[i].ef);
        end

        // Opening travel timeout: u high for exactly 8 cycles, then Fault.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("to_closed", S_CLOSED, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("to_opening", S_OPENING, 1, 0, 0);
        set_in(0, 0, 0, 0, 0);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (State != S_OPENING) break;
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL open_timeout_len: got %0d cycles of u, expected 8", n);
        end
        check("open_timeout_fault", S_FAULT, 0, 0, 1);

        // Fault is absorbing whatever the inputs do.
        for (int k = 0; k < 20; k++) begin
            step(0, k[0], k[1], k[2] & ~k[1], k[3]);
            check($sformatf("fault_hold%0d", k), S_FAULT, 0, 0, 1);
        end

        // Closing travel timeout.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        check("to_closing", S_CLOSING, 0, 1, 0);
        set_in(0, 0, 0, 0, 0);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (State != S_CLOSING) break;
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL close_timeout_len: got %0d cycles of d, expected 8", n);
        end
        check("close_timeout_fault", S_FAULT, 0, 0, 1);

        // Reset asserted between edges mid-Closing stops the motor at once.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        set_in(0, 0, 0, 0, 0);
        #1;
        check("closing_before_rst", S_CLOSING, 0, 1, 0);
        #1;
        r = 1'b1;
        #1;
        check("async_rst_stop", S_RESOLVE, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("after_async_rst", S_OPENING, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timed_opener.md
TIMED_OPENER -- requirements
Module: timed_opener

Interface
REQ-001 SHALL have parameter AUTO_CLOSE_CYCLES, default 100: consecutive idle cycles in Open before auto-close; 0 disables auto-close.
REQ-002 SHALL have parameter TRAVEL_TIMEOUT, default 200: maximum cycles in Opening or Closing before Fault; range 1 or more.
REQ-003 SHALL have parameter MAX_REVERSALS, default 3: Closing-to-Opening reversals allowed before Fault; range 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes occur on its rising edge.
REQ-005 SHALL have port r, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port b, input, 1 bit: push button.
REQ-007 SHALL have port c, input, 1 bit: fully-closed limit switch.
REQ-008 SHALL have port o, input, 1 bit: fully-open limit switch.
REQ-009 SHALL have port s, input, 1 bit: obstruction sensor.
REQ-010 SHALL have port d, output, 1 bit: motor down.
REQ-011 SHALL have port u, output, 1 bit: motor up.
REQ-012 SHALL have port fault, output, 1 bit: latched fault indication.
REQ-013 SHALL have port State, output, 3 bits, with encoding Closed=0, Opening=1, Open=2, Closing=3, Resolve=4, Fault=5.

Function
REQ-014 Outputs SHALL be Moore: u=1 only in Opening; d=1 only in Closing; fault=1 only in Fault; u and d SHALL never both be 1.
REQ-015 Resolve, on the first edge with r=0: c&o -> Fault; c -> Closed; o -> Open; neither -> Opening.
REQ-016 Closed: b=1 -> Opening; otherwise hold.
REQ-017 Opening: o=1 -> Open.
REQ-018 Opening: if o stays 0 at the edge ending the TRAVEL_TIMEOUT-th cycle in Opening -> Fault.
REQ-019 Open: b=1 & s=0 -> Closing; b=1 & s=1 -> hold.
REQ-020 Open, idle timer: counts cycles with b=0 & s=0; clears on any cycle with b=1 or s=1 and on entry to Open.
REQ-021 Open, auto-close: at the edge ending the AUTO_CLOSE_CYCLES-th consecutive idle cycle -> Closing.
REQ-022 Closing, priority: s=1 or b=1 -> Opening and increments the reversal count; this takes priority over c=1.
REQ-023 Closing: if REQ-022 would make the reversal count reach MAX_REVERSALS -> Fault instead of Opening.
REQ-024 Closing: otherwise c=1 -> Closed and the reversal count clears.
REQ-025 Closing: timeout identical to REQ-018, with c in place of o.
REQ-026 In every state except Resolve: c=1 & o=1 sampled together -> Fault; this has the highest priority.
REQ-027 Fault SHALL be absorbing; it is exited only by r.
REQ-028 The travel counter SHALL clear on each entry to Opening or Closing, including a reversal.
REQ-029 Counter width SHALL be $clog2(max(AUTO_CLOSE_CYCLES, TRAVEL_TIMEOUT)+1); counters SHALL saturate and never wrap.

Reset
REQ-030 While r=1, State SHALL be Resolve, u=d=fault=0, and all counters, including the reversal count, SHALL be 0, asynchronously.
REQ-031 Asserting r mid-travel SHALL stop the motor immediately, without waiting for a clock edge.

Structure
REQ-032 State encodings SHALL live in shared package opener_pkg, which SHALL also hold the state type and the counter-width function.
REQ-033 One sub-module, cycle_timer (parametrised width, with clear, enable and terminal-count flag), SHALL be instantiated twice: once for travel, once for auto-close.
REQ-034 The reversal counter SHALL stay inline.

Verification (AUTO_CLOSE_CYCLES=4, TRAVEL_TIMEOUT=8, MAX_REVERSALS=2, clock period 10)
REQ-035 Reset, then release: r=1 then r=0 with c=0, o=0 -> State=Resolve, then Opening after 1 edge, u=1; separately with o=1 -> Open, u=d=0; separately with c=1 -> Closed.
REQ-036 Full cycle and auto-close: Closed, b pulse -> Opening; o=1 -> Open; hold b=s=0 for 4 cycles -> Closing, d=1; o=0, then c=1 -> Closed, d=0.
REQ-037 Obstruction and reversal limit: Open, b=1 -> Closing; s=1 -> Opening (count 1); o=1, b=1 -> Closing; s=1 -> Fault, fault=1, u=d=0; Fault persists for 20 cycles until r.
REQ-038 Travel timeout: Closed, b pulse, o held 0 -> u=1 for exactly 8 cycles, then Fault.
REQ-039 Conflicts and reset: c=o=1 in Open -> Fault on the next edge; s=1 & c=1 together in Closing -> Opening; r asserted mid-Closing between edges -> d=0 immediately.
